// File: rtl/branch_cond_unit.sv
// branch_cond_unit: two-stage elastic branch-condition evaluator.
// Stage 1 captures per-chunk zero flags of the reduced operand, the sign of a
// and the mode. Stage 2 folds the chunk flags into the zero flag, evaluates the
// branch condition and holds the result until the consumer takes it.
// A saturating counter tracks consumed results that were taken.

module branch_cond_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             zero,
    output logic             taken,
    output logic             err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_taken
);

    localparam int NCH = WIDTH / CHUNK;

    localparam logic [2:0] M_ZERO = 3'd0;
    localparam logic [2:0] M_EQ   = 3'd1;
    localparam logic [2:0] M_NE   = 3'd2;
    localparam logic [2:0] M_LEZ  = 3'd3;
    localparam logic [2:0] M_GTZ  = 3'd4;
    localparam logic [2:0] M_LTZ  = 3'd5;
    localparam logic [2:0] M_GEZ  = 3'd6;

    logic [WIDTH-1:0] r;
    logic [NCH-1:0]   cz_next;

    logic             v1;
    logic [NCH-1:0]   cz;
    logic             s1_sign;
    logic [2:0]       s1_mode;

    logic             s1_adv;
    logic             in_fire;
    logic             out_fire;
    logic             z_red;
    logic             taken_next;
    logic             err_next;

    // Reduce operands and compute first-level chunk zero flags for stage 1.
    always_comb begin
        r       = (mode == M_EQ || mode == M_NE) ? (a ^ b) : a;
        cz_next = '0;
        for (int i = 0; i < NCH; i++) begin
            cz_next[i] = (r[i*CHUNK +: CHUNK] == '0);
        end
    end

    // Stage 1 may take a new beat when empty or when it is moving into stage 2;
    // this depends only on pipeline state and out_ready, never on in_valid.
    assign s1_adv   = v1 && (!out_valid || out_ready);
    assign in_ready = !v1 || !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign z_red    = &cz;

    // Evaluate the branch condition from the stage-1 contents.
    always_comb begin
        taken_next = 1'b0;
        err_next   = 1'b0;
        case (s1_mode)
            M_ZERO:  taken_next = z_red;
            M_EQ:    taken_next = z_red;
            M_NE:    taken_next = !z_red;
            M_LEZ:   taken_next = s1_sign | z_red;
            M_GTZ:   taken_next = !s1_sign & !z_red;
            M_LTZ:   taken_next = s1_sign;
            M_GEZ:   taken_next = !s1_sign;
            default: begin
                taken_next = 1'b0;
                err_next   = 1'b1;
            end
        endcase
    end

    // Stage 1 register: load on accept, empty when advancing with no new beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            cz      <= '0;
            s1_sign <= 1'b0;
            s1_mode <= 3'd0;
        end else if (in_fire) begin
            v1      <= 1'b1;
            cz      <= cz_next;
            s1_sign <= a[WIDTH-1];
            s1_mode <= mode;
        end else if (s1_adv) begin
            v1      <= 1'b0;
        end
    end

    // Stage 2 output register: results stay frozen while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            zero      <= 1'b0;
            taken     <= 1'b0;
            err       <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            zero      <= z_red;
            taken     <= taken_next;
            err       <= err_next;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating taken counter; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_taken <= '0;
        end else if (cnt_clr) begin
            cnt_taken <= '0;
        end else if (out_fire && taken && (cnt_taken != {CNT_W{1'b1}})) begin
            cnt_taken <= cnt_taken + 1'b1;
        end
    end

endmodule
